// File: rtl/a4092_pkg.sv
// Shared constants and state encodings for the A4092 Zorro III AutoConfig logic.
package a4092_pkg;

   localparam logic [6:0] CFG_BASE_REG   = 7'h11;
   localparam logic [6:0] CFG_SHUTUP_REG = 7'h13;

   localparam logic [7:0] CFG_TYPE  = 8'h90;
   localparam logic [7:0] CFG_FLAGS = 8'h30;
   localparam logic [7:0] CFG_SPACE = 8'hFF;

   typedef enum logic [1:0] {UNCONF, CONFIGURED, SHUTUP} cfg_state_t;
   typedef enum logic [1:0] {IDLE, DECODE, WAIT, ACK} cyc_state_t;

endpackage

// File: rtl/autoconfig_rom.sv
// AutoConfig identity table: register index -> nibble, combinational.
// Index bit 6 (A8) picks the low nibble; every byte except type reads inverted.
module autoconfig_rom
   import a4092_pkg::*;
#(
   parameter logic [15:0] MANUF_ID   = 16'h0202,
   parameter logic [7:0]  PRODUCT_ID = 8'h54,
   parameter logic [31:0] SERIAL     = 32'h0000_0000,
   parameter logic [15:0] ROM_VEC    = 16'h0000
) (
   input  logic [6:0] reg_idx,
   output logic [3:0] nibble
);

   logic [7:0] raw_byte;
   logic [7:0] cfg_byte;

   always_comb begin
      raw_byte = 8'h00;
      case (reg_idx[5:0])
         6'h00: raw_byte = CFG_TYPE;
         6'h01: raw_byte = PRODUCT_ID;
         6'h02: raw_byte = CFG_FLAGS;
         6'h04: raw_byte = MANUF_ID[15:8];
         6'h05: raw_byte = MANUF_ID[7:0];
         6'h06: raw_byte = SERIAL[31:24];
         6'h07: raw_byte = SERIAL[23:16];
         6'h08: raw_byte = SERIAL[15:8];
         6'h09: raw_byte = SERIAL[7:0];
         6'h0A: raw_byte = ROM_VEC[15:8];
         6'h0B: raw_byte = ROM_VEC[7:0];
         default: raw_byte = 8'h00;
      endcase
   end

   assign cfg_byte = (reg_idx[5:0] == 6'h00) ? raw_byte : ~raw_byte;
   assign nibble   = reg_idx[6] ? cfg_byte[3:0] : cfg_byte[7:4];

endmodule

// File: rtl/zorro3_autoconfig.sv
// Zorro III AutoConfig responder and slave-cycle qualifier for the A4092.
// Config ack 3 CLKs after FCS_n low, slave qualify after 2; everything held until FCS_n rises.
module zorro3_autoconfig
   import a4092_pkg::*;
#(
   parameter logic [15:0] MANUF_ID   = 16'h0202,
   parameter logic [7:0]  PRODUCT_ID = 8'h54,
   parameter logic [31:0] SERIAL     = 32'h0000_0000,
   parameter logic [15:0] ROM_VEC    = 16'h0000
) (
   input  logic         CLK,
   input  logic         RESET_n,
   input  logic [31:2]  ADDR,
   input  logic         FCS_n,
   input  logic         READ,
   input  logic         CFGIN_n,
   input  logic [31:16] DATA_IN,
   output logic [31:28] DATA_OUT,
   output logic         data_oe,
   output logic         cfg_dtack,
   output logic         CFGOUT_n,
   output logic         slave_cycle,
   output logic         configured,
   output logic         shutup,
   output logic [7:0]   base_addr
);

   cfg_state_t cfg_state;
   cyc_state_t cyc_state;
   logic [7:0] cap_hi;
   logic [6:0] cap_idx;
   logic       cap_read;
   logic [3:0] rom_nibble;
   logic       cfg_hit;
   logic       slave_hit;

   logic unused_bits;
   assign unused_bits = ^{ADDR[23:9], DATA_IN[23:16]};

   autoconfig_rom #(
      .MANUF_ID   (MANUF_ID),
      .PRODUCT_ID (PRODUCT_ID),
      .SERIAL     (SERIAL),
      .ROM_VEC    (ROM_VEC)
   ) u_rom (
      .reg_idx (cap_idx),
      .nibble  (rom_nibble)
   );

   assign configured = (cfg_state == CONFIGURED);
   assign shutup     = (cfg_state == SHUTUP);

   // CFGIN_n only matters here, as sampled in DECODE.
   assign cfg_hit   = (cap_hi == CFG_SPACE) && !CFGIN_n && (cfg_state == UNCONF);
   assign slave_hit = configured && (cap_hi == base_addr) && !cfg_hit;

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         cfg_state   <= UNCONF;
         cyc_state   <= IDLE;
         cap_hi      <= 8'h00;
         cap_idx     <= 7'h00;
         cap_read    <= 1'b0;
         base_addr   <= 8'h00;
         DATA_OUT    <= 4'hF;
         data_oe     <= 1'b0;
         cfg_dtack   <= 1'b0;
         slave_cycle <= 1'b0;
         CFGOUT_n    <= 1'b1;
      end else begin
         CFGOUT_n <= !(configured || shutup);
         case (cyc_state)
            IDLE: begin
               if (!FCS_n) begin
                  cap_hi    <= ADDR[31:24];
                  cap_idx   <= ADDR[8:2];
                  cap_read  <= READ;
                  cyc_state <= DECODE;
               end
            end
            DECODE: begin
               if (FCS_n) begin
                  cyc_state <= IDLE;
               end else if (cfg_hit) begin
                  DATA_OUT  <= rom_nibble;
                  cyc_state <= WAIT;
               end else if (slave_hit) begin
                  slave_cycle <= 1'b1;
                  cyc_state   <= ACK;
               end else begin
                  cyc_state <= ACK;
               end
            end
            WAIT: begin
               // An abandoned cycle must not commit a write.
               if (FCS_n) begin
                  cyc_state <= IDLE;
               end else begin
                  cfg_dtack <= 1'b1;
                  data_oe   <= cap_read;
                  cyc_state <= ACK;
                  if (!cap_read && cfg_state == UNCONF) begin
                     if (cap_idx == CFG_BASE_REG) begin
                        base_addr <= DATA_IN[31:24];
                        cfg_state <= CONFIGURED;
                     end else if (cap_idx == CFG_SHUTUP_REG) begin
                        cfg_state <= SHUTUP;
                     end
                  end
               end
            end
            ACK: begin
               if (FCS_n) begin
                  cfg_dtack   <= 1'b0;
                  data_oe     <= 1'b0;
                  slave_cycle <= 1'b0;
                  cyc_state   <= IDLE;
               end
            end
            default: cyc_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_zorro3_autoconfig.sv
// Scoreboard bench for zorro3_autoconfig: directed AutoConfig scenarios plus random bus cycles.
module tb_zorro3_autoconfig;

   localparam logic [15:0] P_MANUF  = 16'h0202;
   localparam logic [7:0]  P_PROD   = 8'h54;
   localparam logic [31:0] P_SERIAL = 32'h1234_5678;
   localparam logic [15:0] P_ROM    = 16'hABCD;

   logic         CLK = 1'b0;
   logic         RESET_n;
   logic [31:2]  ADDR;
   logic         FCS_n;
   logic         READ;
   logic         CFGIN_n;
   logic [31:16] DATA_IN;
   logic [31:28] DATA_OUT;
   logic         data_oe, cfg_dtack, CFGOUT_n, slave_cycle, configured, shutup;
   logic [7:0]   base_addr;

   zorro3_autoconfig #(
      .MANUF_ID(P_MANUF), .PRODUCT_ID(P_PROD), .SERIAL(P_SERIAL), .ROM_VEC(P_ROM)
   ) dut (
      .CLK(CLK), .RESET_n(RESET_n), .ADDR(ADDR), .FCS_n(FCS_n), .READ(READ),
      .CFGIN_n(CFGIN_n), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .data_oe(data_oe),
      .cfg_dtack(cfg_dtack), .CFGOUT_n(CFGOUT_n), .slave_cycle(slave_cycle),
      .configured(configured), .shutup(shutup), .base_addr(base_addr)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         d_idx;
      int         s_idx;
      bit         rd;
      logic [3:0] dat;
      bit         conf;
      bit         shut;
      logic [7:0] base;
   } exp_t;

   exp_t q[$];
   int   nvec = 0;
   int   nerr = 0;
   bit   mon_en = 1'b0;

   // reference board state: 0 unconfigured, 1 configured, 2 shut up
   int         m_state;
   logic [7:0] m_base;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   function automatic logic [3:0] ref_nibble(input logic [31:0] a);
      logic [7:0] off;
      logic [7:0] b;
      off = {a[7:2], 2'b00};
      case (off)
         8'h00: b = 8'h90;
         8'h04: b = P_PROD;
         8'h08: b = 8'h30;
         8'h10: b = P_MANUF[15:8];
         8'h14: b = P_MANUF[7:0];
         8'h18: b = P_SERIAL[31:24];
         8'h1C: b = P_SERIAL[23:16];
         8'h20: b = P_SERIAL[15:8];
         8'h24: b = P_SERIAL[7:0];
         8'h28: b = P_ROM[15:8];
         8'h2C: b = P_ROM[7:0];
         default: b = 8'h00;
      endcase
      if (off != 8'h00) b = ~b;
      return a[8] ? b[3:0] : b[7:4];
   endfunction

   // hold = number of CLK edges at which FCS_n is sampled low
   task automatic bus_cycle(input logic [31:0] a, input bit rd, input logic [15:0] din,
                            input bit cfgin, input int hold);
      exp_t e;
      bit   chit;
      chit   = (a[31:24] == 8'hFF) && !cfgin && (m_state == 0) && (hold >= 2);
      e.rd   = rd;
      e.d_idx = (chit && hold >= 3) ? 3 : 0;
      e.s_idx = ((m_state == 1) && (a[31:24] == m_base) && (hold >= 2)) ? 2 : 0;
      e.dat  = ref_nibble(a);
      if (e.d_idx != 0 && !rd) begin
         if (a[8:0] == 9'h044) begin
            m_state = 1;
            m_base  = din[15:8];
         end else if (a[8:0] == 9'h04C) begin
            m_state = 2;
         end
      end
      e.conf = (m_state == 1);
      e.shut = (m_state == 2);
      e.base = m_base;
      q.push_back(e);

      ADDR    = a[31:2];
      READ    = rd;
      DATA_IN = din;
      CFGIN_n = cfgin;
      FCS_n   = 1'b0;
      for (int i = 1; i <= hold; i++) begin
         @(negedge CLK);
         if (i == 2) CFGIN_n = ~cfgin;
      end
      FCS_n = 1'b1;
      repeat (3) @(negedge CLK);
   endtask

   task automatic do_reset();
      RESET_n = 1'b0;
      FCS_n   = 1'b1;
      m_state = 0;
      m_base  = 8'h00;
      repeat (2) @(negedge CLK);
      RESET_n = 1'b1;
      @(negedge CLK);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " DATA_OUT"},    DATA_OUT,    4'hF);
      check({tag, " data_oe"},     data_oe,     1'b0);
      check({tag, " cfg_dtack"},   cfg_dtack,   1'b0);
      check({tag, " CFGOUT_n"},    CFGOUT_n,    1'b1);
      check({tag, " slave_cycle"}, slave_cycle, 1'b0);
      check({tag, " configured"},  configured,  1'b0);
      check({tag, " shutup"},      shutup,      1'b0);
      check({tag, " base_addr"},   base_addr,   8'h00);
   endtask

   task automatic random_cycles(input int n);
      logic [31:0] a;
      logic [6:0]  idx;
      bit          rd, cfgin;
      int          hold, r;
      for (int i = 0; i < n; i++) begin
         rd  = ($urandom_range(0, 1) == 1);
         idx = 7'($urandom_range(0, 127));
         if (!rd && $urandom_range(0, 5) == 0)
            idx = ($urandom_range(0, 1) == 1) ? 7'h11 : 7'h13;
         r = $urandom_range(0, 3);
         a = $urandom;
         a[31:24] = (r < 2) ? 8'hFF : (r == 2) ? m_base : a[31:24];
         a[8:2]   = idx;
         a[1:0]   = 2'b00;
         cfgin = ($urandom_range(0, 4) == 0);
         r     = $urandom_range(0, 7);
         hold  = (r == 0) ? 1 : (r == 1) ? 2 : $urandom_range(3, 6);
         bus_cycle(a, rd, 16'($urandom), cfgin, hold);
      end
   endtask

   // monitor: measures each bus cycle and compares against the queued expectation
   initial begin : monitor
      int         k, hi, d_idx, s_idx;
      bit         oe_any, fcs_s;
      logic [3:0] d_dat;
      exp_t       e;
      k = 0; hi = 0; d_idx = 0; s_idx = 0; oe_any = 0; d_dat = 4'h0;
      forever begin
         @(posedge CLK);
         fcs_s = FCS_n;
         @(negedge CLK);
         if (!mon_en) begin
            k = 0; hi = 0;
         end else if (!fcs_s) begin
            if (k == 0) begin
               d_idx = 0; s_idx = 0; oe_any = 0; d_dat = 4'h0;
            end
            k++;
            hi = 0;
            if (cfg_dtack && d_idx == 0) begin
               d_idx = k;
               d_dat = DATA_OUT;
            end
            if (slave_cycle && s_idx == 0) s_idx = k;
            if (data_oe) oe_any = 1'b1;
         end else if (k > 0) begin
            hi++;
            if (hi == 2) begin
               if (q.size() == 0) begin
                  nvec++; nerr++;
                  $display("FAIL scoreboard: bus cycle seen with no expectation queued");
               end else begin
                  e = q.pop_front();
                  check("dtack latency", d_idx, e.d_idx);
                  check("slave latency", s_idx, e.s_idx);
                  check("data_oe asserted", oe_any, (e.d_idx != 0) && e.rd);
                  if (e.d_idx != 0 && e.rd) check("config nibble", d_dat, e.dat);
                  check("dtack released", cfg_dtack, 1'b0);
                  check("slave released", slave_cycle, 1'b0);
                  check("oe released", data_oe, 1'b0);
                  check("configured", configured, e.conf);
                  check("shutup", shutup, e.shut);
                  check("CFGOUT_n", CFGOUT_n, !(e.conf || e.shut));
                  check("base_addr", base_addr, e.base);
               end
               k = 0; hi = 0;
            end
         end
      end
   end

   initial begin : stim
      int guard;
      ADDR = '0; READ = 1'b1; DATA_IN = '0; CFGIN_n = 1'b0;
      do_reset();
      check_reset_outputs("reset");
      mon_en = 1'b1;

      bus_cycle(32'hFF00_0000, 1, 16'h0, 0, 6);
      bus_cycle(32'hFF00_0100, 1, 16'h0, 0, 6);
      bus_cycle(32'hFF00_0004, 1, 16'h0, 0, 6);
      bus_cycle(32'hFF00_0104, 1, 16'h0, 0, 6);
      bus_cycle(32'hFF00_0040, 1, 16'h0, 0, 6);
      bus_cycle(32'hFF00_0000, 1, 16'h0, 1, 6);
      bus_cycle(32'hFF00_0044, 0, 16'h7700, 0, 2);
      bus_cycle(32'hFF00_0044, 0, 16'h4000, 0, 6);
      bus_cycle(32'h4010_0000, 1, 16'h0, 0, 6);
      bus_cycle(32'h4100_0000, 1, 16'h0, 0, 6);
      bus_cycle(32'hFF00_0000, 1, 16'h0, 0, 6);

      mon_en = 1'b0;
      do_reset();
      mon_en = 1'b1;
      bus_cycle(32'hFF00_004C, 0, 16'h4000, 0, 4);
      bus_cycle(32'hFF00_0000, 1, 16'h0, 0, 6);

      for (int s = 0; s < 3; s++) begin
         mon_en = 1'b0;
         do_reset();
         mon_en = 1'b1;
         random_cycles(50);
      end

      guard = 0;
      while (q.size() != 0 && guard < 50) begin
         @(negedge CLK);
         guard++;
      end
      check("scoreboard drained", q.size(), 0);

      // reset in the middle of an acknowledged config read
      mon_en = 1'b0;
      do_reset();
      ADDR = 30'h3FC0_0000; READ = 1'b1; CFGIN_n = 1'b0; FCS_n = 1'b0;
      repeat (4) @(negedge CLK);
      check("ack before reset", cfg_dtack, 1'b1);
      check("nibble before reset", DATA_OUT, 4'h9);
      #1 RESET_n = 1'b0;
      #1 check_reset_outputs("mid-cycle reset");
      FCS_n = 1'b1;
      @(negedge CLK);
      RESET_n = 1'b1;
      repeat (2) @(negedge CLK);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
